exmem_skid_stage: RTL and testbench

EXMEM_SKID_STAGE -- requirements
Module: exmem_skid_stage

---
 rtl/exmem_skid_stage.sv | 116 +++++++++++
 tb/tb_exmem_skid_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer: a head (main) entry
// drives the outputs and a skid entry absorbs one beat so in_ready is purely registered.
module exmem_skid_stage #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_alu,
    input  logic [WIDTH-1:0]  in_wdata,
    input  logic [WIDTH-1:0]  in_target,
    input  logic [4:0]        in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_alu,
    output logic [WIDTH-1:0]  out_wdata,
    output logic [WIDTH-1:0]  out_target,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned PAY_W = 3 * WIDTH + 5 + CTRL_W;

    logic             main_valid;
    logic             skid_valid;
    logic [PAY_W-1:0] main_pay;
    logic [PAY_W-1:0] skid_pay;

    logic             main_valid_nxt;
    logic             skid_valid_nxt;
    logic [PAY_W-1:0] main_pay_nxt;
    logic [PAY_W-1:0] skid_pay_nxt;

    logic [PAY_W-1:0]  in_pay;
    logic [CTRL_W-1:0] main_ctrl;
    logic              in_fire;
    logic              out_fire;
    logic [1:0]        occ_q;
    logic [CNT_W-1:0]  stall_q;

    assign in_pay   = {in_alu, in_wdata, in_target, in_rd, in_ctrl};
    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

    assign out_valid = main_valid;
    assign {out_alu, out_wdata, out_target, out_rd, main_ctrl} = main_pay;
    // A bubble must never carry live regwrite/memwrite bits downstream.
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        main_pay_nxt   = main_pay;
        skid_pay_nxt   = skid_pay;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
            main_pay_nxt   = '0;
            skid_pay_nxt   = '0;
        end else if (!main_valid) begin
            if (in_fire) begin
                main_valid_nxt = 1'b1;
                main_pay_nxt   = in_pay;
            end
        end else if (out_fire) begin
            // A full skid implies in_ready=0, so skid refill and input load never collide.
            if (skid_valid) begin
                main_pay_nxt   = skid_pay;
                skid_valid_nxt = 1'b0;
            end else if (in_fire) begin
                main_pay_nxt = in_pay;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_nxt = 1'b1;
            skid_pay_nxt   = in_pay;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_pay   <= '0;
            skid_pay   <= '0;
            occ_q      <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            main_pay   <= main_pay_nxt;
            skid_pay   <= skid_pay_nxt;
            occ_q      <= {1'b0, main_valid_nxt} + {1'b0, skid_valid_nxt};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready && !(&stall_q)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed bench for exmem_skid_stage: streaming, backpressure, bubble kill,
// flush, stall-counter saturation and mid-operation reset.
module tb_exmem_skid_stage;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_alu;
    logic [WIDTH-1:0]  in_wdata;
    logic [WIDTH-1:0]  in_target;
    logic [4:0]        in_rd;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_alu;
    logic [WIDTH-1:0]  out_wdata;
    logic [WIDTH-1:0]  out_target;
    logic [4:0]        out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks;
    int n_errors;

    exmem_skid_stage #(
        .WIDTH  (WIDTH),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu     (in_alu),
        .in_wdata   (in_wdata),
        .in_target  (in_target),
        .in_rd      (in_rd),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu    (out_alu),
        .out_wdata  (out_wdata),
        .out_target (out_target),
        .out_rd     (out_rd),
        .out_ctrl   (out_ctrl),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] alu, input logic [4:0] rd,
                         input logic [CTRL_W-1:0] ctrl);
        in_valid  = v;
        in_alu    = alu;
        in_wdata  = alu + 64'h100;
        in_target = alu + 64'h200;
        in_rd     = rd;
        in_ctrl   = ctrl;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'h0, 5'd0, '0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_occ", occupancy, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_out_alu", out_alu, 0);

        // Bubble kill: ctrl lines high but nothing valid
        drive(1'b0, 64'h55, 5'd3, 5'b11111);
        tick();
        check("bubble_valid", out_valid, 0);
        check("bubble_ctrl", out_ctrl, 0);
        check("bubble_stall", stall_cnt, 0);

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(i), 5'(i), 5'b00001);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_alu", out_alu, 64'(i));
            check("stream_rd", out_rd, 64'(i));
            check("stream_occ", occupancy, 1);
            check("stream_ctrl", out_ctrl, 5'b00001);
        end
        drive(1'b0, 64'h0, 5'd0, 5'b11111);
        tick();
        check("stream_drain_valid", out_valid, 0);
        check("stream_drain_occ", occupancy, 0);
        check("stream_drain_ctrl", out_ctrl, 0);
        check("stream_stall", stall_cnt, 0);

        // Backpressure: A then B with downstream stalled
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 5'd10, 5'b01010);
        tick();
        check("bp_a_alu", out_alu, 64'hA);
        check("bp_a_occ", occupancy, 1);
        check("bp_a_ready", in_ready, 1);
        check("bp_a_stall", stall_cnt, 0);
        drive(1'b1, 64'hB, 5'd11, 5'b00011);
        tick();
        check("bp_b_ready", in_ready, 0);
        check("bp_b_occ", occupancy, 2);
        check("bp_b_head", out_alu, 64'hA);
        check("bp_b_stall", stall_cnt, 1);
        drive(1'b0, 64'h0, 5'd0, '0);
        tick();
        check("bp_hold_alu", out_alu, 64'hA);
        check("bp_hold_wdata", out_wdata, 64'h10A);
        check("bp_hold_target", out_target, 64'h20A);
        check("bp_hold_ctrl", out_ctrl, 5'b01010);
        check("bp_hold_stall", stall_cnt, 2);
        out_ready = 1'b1;
        tick();
        check("bp_deliver_b_alu", out_alu, 64'hB);
        check("bp_deliver_b_rd", out_rd, 11);
        check("bp_deliver_b_ctrl", out_ctrl, 5'b00011);
        check("bp_deliver_b_occ", occupancy, 1);
        check("bp_deliver_b_ready", in_ready, 1);
        tick();
        check("bp_empty_valid", out_valid, 0);
        check("bp_final_stall", stall_cnt, 2);

        // Flush with both entries held and a simultaneous push of C
        out_ready = 1'b0;
        drive(1'b1, 64'hD, 5'd13, 5'b00001);
        tick();
        drive(1'b1, 64'hE, 5'd14, 5'b00001);
        tick();
        check("fl_pre_occ", occupancy, 2);
        check("fl_pre_stall", stall_cnt, 3);
        flush = 1'b1;
        drive(1'b1, 64'hC, 5'd12, 5'b00001);
        #2;
        check("fl_cycle_alu", out_alu, 64'hD);
        check("fl_cycle_valid", out_valid, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(1'b0, 64'h0, 5'd0, '0);
        check("fl_occ", occupancy, 0);
        check("fl_valid", out_valid, 0);
        check("fl_alu", out_alu, 0);
        check("fl_wdata", out_wdata, 0);
        check("fl_ready", in_ready, 1);
        check("fl_stall", stall_cnt, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_c", out_valid, 0);
        end

        // Reset mid-stall with both entries full
        out_ready = 1'b0;
        drive(1'b1, 64'hF, 5'd15, 5'b00001);
        tick();
        drive(1'b1, 64'h10, 5'd16, 5'b00001);
        tick();
        drive(1'b0, 64'h0, 5'd0, '0);
        tick();
        tick();
        check("rm_pre_occ", occupancy, 2);
        check("rm_pre_stall", stall_cnt, 7);
        reset = 1'b1;
        drive(1'b1, 64'h77, 5'd7, 5'b11111);
        tick();
        reset = 1'b0;
        drive(1'b0, 64'h0, 5'd0, '0);
        check("rm_occ", occupancy, 0);
        check("rm_stall", stall_cnt, 0);
        check("rm_ready", in_ready, 1);
        check("rm_valid", out_valid, 0);
        check("rm_alu", out_alu, 0);
        check("rm_ctrl", out_ctrl, 0);

        // Saturation of the 4-bit stall counter, then flush leaves it alone
        drive(1'b1, 64'h99, 5'd9, 5'b00001);
        tick();
        drive(1'b0, 64'h0, 5'd0, '0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_14", stall_cnt, 14);
        end
        check("sat_max", stall_cnt, 4'hF);
        check("sat_head", out_alu, 64'h99);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_after_flush", stall_cnt, 4'hF);
        check("sat_flush_occ", occupancy, 0);
        tick();
        check("sat_idle", stall_cnt, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
